// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the arbiter, its two requesters (IF, LS) and the shared
// combinational-read memory.
interface mem_port_arbiter_if #(
    parameter int unsigned DATA_WIDTH = 32
);
    logic                  if_req;
    logic [DATA_WIDTH-1:0] if_addr;
    logic                  if_gnt;
    logic                  if_valid;
    logic [DATA_WIDTH-1:0] if_rdata;

    logic                  ls_req;
    logic                  ls_we;
    logic [DATA_WIDTH-1:0] ls_addr;
    logic [DATA_WIDTH-1:0] ls_wdata;
    logic                  ls_gnt;
    logic                  ls_valid;
    logic [DATA_WIDTH-1:0] ls_rdata;

    logic [DATA_WIDTH-1:0] mem_word_addr;
    logic                  mem_we;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic                  addr_err;

    modport slave (
        input  if_req, if_addr, ls_req, ls_we, ls_addr, ls_wdata, mem_rdata,
        output if_gnt, if_valid, if_rdata, ls_gnt, ls_valid, ls_rdata,
               mem_word_addr, mem_we, mem_wdata, addr_err
    );

    modport master (
        output if_req, if_addr, ls_req, ls_we, ls_addr, ls_wdata, mem_rdata,
        input  if_gnt, if_valid, if_rdata, ls_gnt, ls_valid, ls_rdata,
               mem_word_addr, mem_we, mem_wdata, addr_err
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one combinational-read memory between the fetch (IF) and load/store
// (LS) ports through an IDLE -> ACCESS -> RESP sequence with registered outputs.
module mem_port_arbiter #(
    parameter int unsigned           DATA_WIDTH   = 32,
    parameter int unsigned           MEMORY_DEPTH = 32,
    parameter logic [DATA_WIDTH-1:0] BASE_ADDR    = 32'h0040_0000,
    parameter int unsigned           MAX_WAIT     = 4
) (
    input logic               clk,
    input logic               reset,
    mem_port_arbiter_if.slave bus
);
    localparam logic [3:0]            MAX_WAIT_C = 4'(MAX_WAIT);
    localparam logic [DATA_WIDTH-1:0] DEPTH_C    = DATA_WIDTH'(MEMORY_DEPTH);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t                state;
    logic [3:0]            wait_cnt;
    logic                  cur_ls;
    logic                  cur_fault;

    logic                  gnt_if, gnt_ls, valid_if, valid_ls, err;
    logic [DATA_WIDTH-1:0] rdata_if, rdata_ls;
    logic [DATA_WIDTH-1:0] word_addr, wdata;
    logic                  we;

    logic                  any_req;
    logic                  pick_if;
    logic [DATA_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_index;
    logic                  sel_fault;

    // Offset wraps modulo 2^DATA_WIDTH, so addresses below the base land on huge indices.
    function automatic logic [DATA_WIDTH-1:0] word_index(input logic [DATA_WIDTH-1:0] addr);
        logic [DATA_WIDTH-1:0] offset;
        offset = addr - BASE_ADDR;
        return offset >> 2;
    endfunction

    function automatic logic addr_fault(input logic [DATA_WIDTH-1:0] addr,
                                        input logic [DATA_WIDTH-1:0] index);
        return (addr[1:0] != 2'b00) || (index >= DEPTH_C);
    endfunction

    always_comb begin
        any_req   = bus.if_req | bus.ls_req;
        pick_if   = bus.if_req & (~bus.ls_req | (wait_cnt == MAX_WAIT_C));
        sel_addr  = pick_if ? bus.if_addr : bus.ls_addr;
        sel_index = word_index(sel_addr);
        sel_fault = addr_fault(sel_addr, sel_index);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            wait_cnt  <= '0;
            cur_ls    <= 1'b0;
            cur_fault <= 1'b0;
            gnt_if    <= 1'b0;
            gnt_ls    <= 1'b0;
            valid_if  <= 1'b0;
            valid_ls  <= 1'b0;
            err       <= 1'b0;
            rdata_if  <= '0;
            rdata_ls  <= '0;
            word_addr <= '0;
            wdata     <= '0;
            we        <= 1'b0;
        end else begin
            gnt_if   <= 1'b0;
            gnt_ls   <= 1'b0;
            valid_if <= 1'b0;
            valid_ls <= 1'b0;
            err      <= 1'b0;
            we       <= 1'b0;
            case (state)
                IDLE: begin
                    if (!bus.if_req) begin
                        wait_cnt <= '0;
                    end else if (any_req) begin
                        wait_cnt <= pick_if ? 4'd0 : wait_cnt + 4'd1;
                    end
                    if (any_req) begin
                        cur_ls    <= ~pick_if;
                        cur_fault <= sel_fault;
                        word_addr <= sel_index;
                        gnt_if    <= pick_if;
                        gnt_ls    <= ~pick_if;
                        we        <= ~pick_if & bus.ls_we & ~sel_fault;
                        if (!pick_if) begin
                            wdata <= bus.ls_wdata;
                        end
                        state <= ACCESS;
                    end
                end
                // ACCESS: memory sees the index this cycle; capture its read data at the edge.
                ACCESS: begin
                    if (cur_ls) begin
                        rdata_ls <= cur_fault ? '0 : bus.mem_rdata;
                        valid_ls <= 1'b1;
                    end else begin
                        rdata_if <= cur_fault ? '0 : bus.mem_rdata;
                        valid_if <= 1'b1;
                    end
                    err   <= cur_fault;
                    state <= RESP;
                end
                // RESP: valid pulse is visible; no arbitration so a held req is not re-granted.
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.if_gnt        = gnt_if;
    assign bus.if_valid      = valid_if;
    assign bus.if_rdata      = rdata_if;
    assign bus.ls_gnt        = gnt_ls;
    assign bus.ls_valid      = valid_ls;
    assign bus.ls_rdata      = rdata_ls;
    assign bus.mem_word_addr = word_addr;
    assign bus.mem_we        = we;
    assign bus.mem_wdata     = wdata;
    assign bus.addr_err      = err;
endmodule
